// File: rtl/pckt_rx_queue.sv
// Captures CRC-checked packets from the comm receiver, acks each with a one-cycle pulse, and queues them in a FWFT FIFO.
// Head entry is visible the cycle after the write; the consumer throttles with cmd_rdy, and overflowed packets are dropped and counted.
module pckt_rx_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pckt_rdy,
    input  logic [15:0]      rxdata,
    output logic             clr_pckt_rdy,
    output logic [3:0]       cmd,
    output logic [11:0]      payload,
    output logic             cmd_vld,
    input  logic             cmd_rdy,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

    state_t        state, state_nxt;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          capture, pop, push, drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // WAIT holds off re-capture until the comm module has seen the clear.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: if (pckt_rdy) begin
                capture   = 1'b1;
                state_nxt = ACK;
            end
            ACK:     state_nxt = WAIT;
            WAIT:    if (!pckt_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign clr_pckt_rdy = (state == ACK);

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign cmd_vld = !empty;
    assign pop     = cmd_vld & cmd_rdy;
    assign push    = capture & !flush & (!full | pop);
    assign drop    = capture & !flush & full & !pop;

    assign cmd     = mem[rd_ptr][15:12];
    assign payload = mem[rd_ptr][11:0];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rxdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         drop_cnt <= '0;
        else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pckt_rx_queue.sv
// Bench for pckt_rx_queue: vector table, directed corner sequences, and random traffic against a queue-based reference model.
module tb_pckt_rx_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int MAXD  = (1 << CNT_W) - 1;

    logic             clk, rst, pckt_rdy, cmd_rdy, flush;
    logic [15:0]      rxdata;
    logic             clr_pckt_rdy, cmd_vld, full, empty;
    logic [3:0]       cmd;
    logic [11:0]      payload;
    logic [CNT_W-1:0] drop_cnt;

    pckt_rx_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pckt_rdy(pckt_rdy), .rxdata(rxdata),
        .clr_pckt_rdy(clr_pckt_rdy), .cmd(cmd), .payload(payload),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .flush(flush),
        .full(full), .empty(empty), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: packet queue, ack bookkeeping, drop tally.
    logic [15:0] mq[$];
    int          mdrop;
    bit          m_armed;    // ready to accept a new packet
    bit          m_ack;      // acknowledge visible this cycle
    bit          m_wait_lo;  // waiting for pckt_rdy to fall

    typedef struct {
        logic        prdy;
        logic [15:0] rxd;
        logic        rdy;
        logic        clr;
        logic        vld;
        logic [15:0] head;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mdrop     = 0;
        m_armed   = 1'b1;
        m_ack     = 1'b0;
        m_wait_lo = 1'b0;
    endtask

    task automatic model_edge();
        bit do_pop, cap;
        do_pop = (mq.size() > 0) && cmd_rdy;
        cap    = m_armed && pckt_rdy;
        if (flush) mq.delete();
        else begin
            if (do_pop) void'(mq.pop_front());
            if (cap) begin
                if (mq.size() < DEPTH) mq.push_back(rxdata);
                else if (mdrop < MAXD) mdrop++;
            end
        end
        if (cap) begin
            m_armed = 1'b0; m_ack = 1'b1;
        end else if (m_ack) begin
            m_ack = 1'b0; m_wait_lo = 1'b1;
        end else if (m_wait_lo && !pckt_rdy) begin
            m_wait_lo = 1'b0; m_armed = 1'b1;
        end
    endtask

    task automatic compare_model();
        chk("model.clr",   32'(clr_pckt_rdy), 32'(m_ack));
        chk("model.vld",   32'(cmd_vld), (mq.size() > 0) ? 1 : 0);
        chk("model.empty", 32'(empty),   (mq.size() == 0) ? 1 : 0);
        chk("model.full",  32'(full),    (mq.size() == DEPTH) ? 1 : 0);
        chk("model.drop",  32'(drop_cnt), mdrop);
        if (mq.size() > 0) chk("model.head", 32'({cmd, payload}), 32'(mq[0]));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    // Full comm handshake: capture, ack cycle, then pckt_rdy released.
    task automatic send(input logic [15:0] d);
        pckt_rdy = 1'b1; rxdata = d;
        cycle();
        cycle();
        pckt_rdy = 1'b0;
        cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".clr"},   32'(clr_pckt_rdy), 0);
        chk({tag, ".vld"},   32'(cmd_vld), 0);
        chk({tag, ".empty"}, 32'(empty), 1);
        chk({tag, ".full"},  32'(full), 0);
        chk({tag, ".drop"},  32'(drop_cnt), 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; pckt_rdy = 1'b0; rxdata = '0; cmd_rdy = 1'b0; flush = 1'b0;
        model_reset();

        // Single packet, then sticky pckt_rdy held for ten cycles.
        tbl[0] = '{1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 16'h1234};
        tbl[1] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h1234};
        tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[3] = '{1'b1, 16'h9669, 1'b0, 1'b1, 1'b1, 16'h9669};
        for (int i = 4; i < 13; i++) tbl[i] = '{1'b1, 16'h9669, 1'b0, 1'b0, 1'b1, 16'h9669};
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h9669};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};

        #2;
        apply_reset();

        for (int i = 0; i < 15; i++) begin
            pckt_rdy = tbl[i].prdy; rxdata = tbl[i].rxd; cmd_rdy = tbl[i].rdy;
            cycle();
            chk($sformatf("tbl[%0d].clr", i), 32'(clr_pckt_rdy), 32'(tbl[i].clr));
            chk($sformatf("tbl[%0d].vld", i), 32'(cmd_vld), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk($sformatf("tbl[%0d].cmd", i), 32'(cmd), 32'(tbl[i].head[15:12]));
                chk($sformatf("tbl[%0d].payload", i), 32'(payload), 32'(tbl[i].head[11:0]));
            end
        end
        cmd_rdy = 1'b0;

        // Overflow: six packets into four slots.
        for (int i = 0; i < 6; i++) begin
            send(16'hA000 + 16'(i));
            if (i == 3) chk("ovf.full_after_4", 32'(full), 1);
        end
        chk("ovf.drop", 32'(drop_cnt), 2);
        cmd_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf.pop%0d", i), 32'({cmd, payload}), 32'(16'hA000 + 16'(i)));
            cycle();
        end
        chk("ovf.empty", 32'(empty), 1);
        cmd_rdy = 1'b0;

        // Push and pop in the same cycle while full.
        for (int i = 0; i < 4; i++) send(16'hB000 + 16'(i));
        pckt_rdy = 1'b1; rxdata = 16'hBEEF; cmd_rdy = 1'b1;
        cycle();
        cmd_rdy = 1'b0;
        chk("pp.full", 32'(full), 1);
        chk("pp.drop", 32'(drop_cnt), 2);
        chk("pp.head", 32'({cmd, payload}), 32'(16'hB001));
        cycle();
        pckt_rdy = 1'b0;
        cycle();
        cmd_rdy = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        cmd_rdy = 1'b0;
        chk("pp.empty", 32'(empty), 1);

        // Flush colliding with a capture.
        send(16'hC000);
        send(16'hC001);
        pckt_rdy = 1'b1; rxdata = 16'hABCD; flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush.empty", 32'(empty), 1);
        chk("flush.clr",   32'(clr_pckt_rdy), 1);
        chk("flush.drop",  32'(drop_cnt), 2);
        cycle();
        pckt_rdy = 1'b0;
        cycle();

        // Saturation, then reset in the middle of an ack.
        for (int i = 0; i < 4; i++) send(16'hD000 + 16'(i));
        for (int i = 0; i < 5; i++) send(16'hE000 + 16'(i));
        chk("sat.drop", 32'(drop_cnt), 3);
        pckt_rdy = 1'b1; rxdata = 16'hD00D;
        cycle();
        chk("rst.ack_before", 32'(clr_pckt_rdy), 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        chk("rst.recap_clr",  32'(clr_pckt_rdy), 1);
        chk("rst.recap_head", 32'({cmd, payload}), 32'(16'hD00D));
        cycle();
        pckt_rdy = 1'b0;
        cycle();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            pckt_rdy = ($urandom_range(0, 2) != 0);
            rxdata   = 16'($urandom);
            cmd_rdy  = (i % 500 < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 39) == 0);
            cycle();
        end
        flush = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pckt_rx_queue.md
# pckt_rx_queue

Downstream consumer of the serial comm module's receive side. Captures each CRC-validated 16-bit packet presented on `rxdata`/`pckt_rdy` and acknowledges it with a single-cycle `clr_pckt_rdy` pulse. Buffers packets in a small first-word-fall-through FIFO and presents them to the command processor as a 4-bit opcode plus 12-bit payload, using a valid/ready handshake. Overflowed packets are dropped and counted.

## Interface

- `DEPTH`, default 4: FIFO entries; power of 2, ≥2.
- `CNT_W`, default 8: width of the dropped-packet counter.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pckt_rdy`  in  1  comm module: valid packet held on `rxdata`; stays high until cleared.
- `rxdata`  in  16  comm module received packet.
- `clr_pckt_rdy`  out  1  to comm module: one-cycle acknowledge pulse.
- `cmd`  out  4  head entry `[15:12]`.
- `payload`  out  12  head entry `[11:0]`.
- `cmd_vld`  out  1  FIFO non-empty; `cmd`/`payload` valid.
- `cmd_rdy`  in  1  consumer accepts head entry when high with `cmd_vld`.
- `flush`  in  1  synchronous FIFO clear.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `drop_cnt`  out  `CNT_W`  packets dropped on overflow; saturating.

## Operation

- Capture FSM has three states:
  - IDLE: when `pckt_rdy`=1, attempt a push of `rxdata` and go to ACK.
  - ACK: `clr_pckt_rdy`=1 for exactly this cycle; go to WAIT.
  - WAIT: stay until `pckt_rdy`=0, then go to IDLE. This guarantees one capture per packet even if the clear takes effect late.
- `clr_pckt_rdy` is registered (state decode of ACK) and is high in no other state.
- Push rules:
  - Push succeeds if `!full`, or if a pop occurs in the same cycle.
  - Otherwise the packet is discarded and `drop_cnt` increments.
  - `drop_cnt` saturates at all-ones and no longer wraps.
  - The acknowledge is still issued for dropped packets.
- Pop: occurs when `cmd_vld & cmd_rdy`; the read pointer advances.
- Entry count stays in 0..`DEPTH`. Read and write pointers are log2(`DEPTH`) bits with natural wrap. `full`/`empty` come from an occupancy counter of log2(`DEPTH`)+1 bits.
- Output path is first-word-fall-through: `cmd`/`payload` show the head entry combinationally from storage while `cmd_vld`=1. Their value is don't-care when empty.
- `flush`=1:
  - Pointers and count go to 0 at the edge. Flush beats a same-cycle push or pop.
  - A packet captured in that cycle is discarded and not counted in `drop_cnt`.
  - The FSM still proceeds to ACK.
  - `drop_cnt` is unaffected by flush.
- Reset values:
  - `clr_pckt_rdy`=0, `cmd_vld`=0, `empty`=1, `full`=0, `drop_cnt`=0.
  - FSM in IDLE; pointers and count 0.
- Reset mid-operation (any state) aborts immediately to the reset values. If `pckt_rdy` is still high after reset release, that packet is captured anew.

## Timing

- Capture latency:
  - `pckt_rdy` is sampled high in IDLE at edge N; the FIFO is written at edge N.
  - `cmd_vld` rises in cycle N+1 if the FIFO was previously empty.
  - `clr_pckt_rdy` is high during cycle N+1 only.
- Minimum spacing between captures is 3 cycles: IDLE→ACK→WAIT→IDLE, with `pckt_rdy` low by the WAIT cycle. Each comm packet takes far longer, so back-to-back packets are never lost to the FSM.
- Pop takes effect at the edge where `cmd_vld & cmd_rdy`; the next entry is presented in the following cycle.
- Simultaneous push and pop: the count is unchanged. When full this is legal and loses nothing.
- `cmd_rdy` may be held high permanently; throughput is then one entry per cycle.
- `cmd_vld` never depends combinationally on `cmd_rdy`.

## Test plan

- Single packet: after reset, drive `rxdata`=16'h1234 and `pckt_rdy`=1, dropping `pckt_rdy` the cycle after `clr_pckt_rdy`. Required: `clr_pckt_rdy` high for 1 cycle, then `cmd_vld`=1, `cmd`=4'h1, `payload`=12'h234. With `cmd_rdy`=1, `empty`=1 the next cycle.
- Sticky `pckt_rdy`: hold `pckt_rdy` high 10 cycles with 16'h9669. Required: exactly one push, one `clr_pckt_rdy` pulse, count=1.
- Overflow (DEPTH=4): with `cmd_rdy`=0, deliver packets 16'hA000..16'hA005. Required: `full`=1 after the 4th packet, `drop_cnt`=2. Pops then return A000, A001, A002, A003 in order.
- Push+pop when full: with 4 entries, present 16'hBEEF with `cmd_rdy`=1 in the same cycle. Required: `drop_cnt` unchanged, count stays 4, BEEF is the last entry.
- Flush collision: assert `flush` in the capture cycle of 16'habcd with 2 entries queued. Required: `empty`=1, `drop_cnt` unchanged, `clr_pckt_rdy` still pulses.
- Saturation/reset: with CNT_W=2, drop 5 packets. Required: `drop_cnt`=3. Then assert `rst` mid-ACK. Required: all outputs at reset values immediately; a packet still pending is recaptured after release.
